bsg_gatestack_strobe_gen: RTL and testbench



---
 rtl/bsg_gatestack_pkg.sv | 24 ++
 rtl/bsg_gatestack_phase_counter.sv | 30 +++
 rtl/bsg_gatestack_strobe_gen.sv | 108 ++++++++++
 tb/tb_bsg_gatestack_strobe_gen.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bsg_gatestack_pkg.sv
// Shared types and helpers for the gatestack strobe generator.
// Holds the FSM state enum and the phase-counter width function.
package bsg_gatestack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  function automatic int cnt_width_f(
    input int s,
    input int p,
    input int h
  );
    int m;
    m = s;
    if (p > m) m = p;
    if (h > m) m = h;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bsg_gatestack_phase_counter.sv
// Loadable down-counter; expire_o flags the last cycle of a phase.
// Parks at zero instead of wrapping.
module bsg_gatestack_phase_counter #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic               expire_o
);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (count_q != '0)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign expire_o = (count_q == width_p'(1));

endmodule

// File: rtl/bsg_gatestack_strobe_gen.sv
// Strobe-clocked capture stack driver: launch data, pulse masked strobes.
// Optional done_o pulse via BSG_GATESTACK_STROBE_GEN_DONE_EN.
module bsg_gatestack_strobe_gen
  import bsg_gatestack_pkg::*;
#(
  parameter int width_p        = 16,
  parameter int setup_cycles_p = 1,
  parameter int pulse_cycles_p = 1,
  parameter int hold_cycles_p  = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic [width_p-1:0] mask_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic [width_p-1:0] strobe_o,
  output logic               done_o
);

  localparam int cw_lp =
    cnt_width_f(setup_cycles_p, pulse_cycles_p, hold_cycles_p);
  localparam logic [cw_lp-1:0] s_lp = cw_lp'(setup_cycles_p);
  localparam logic [cw_lp-1:0] p_lp = cw_lp'(pulse_cycles_p);
  localparam logic [cw_lp-1:0] h_lp = cw_lp'(hold_cycles_p);

  state_e             state_q, state_d;
  logic [width_p-1:0] data_q, data_d;
  logic [width_p-1:0] mask_q, mask_d;
  logic [width_p-1:0] strobe_q, strobe_d;
  logic               load;
  logic [cw_lp-1:0]   load_val;
  logic               expire;

  bsg_gatestack_phase_counter #(
    .width_p(cw_lp)
  ) phase_cnt (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (load),
    .load_val_i(load_val),
    .expire_o  (expire)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    mask_d   = mask_q;
    load     = 1'b0;
    load_val = '0;
    unique case (state_q)
      IDLE: if (v_i) begin
        state_d  = SETUP;
        data_d   = data_i;
        mask_d   = mask_i;
        load     = 1'b1;
        load_val = s_lp;
      end
      SETUP: if (expire) begin
        state_d  = PULSE;
        load     = 1'b1;
        load_val = p_lp;
      end
      PULSE: if (expire) begin
        state_d  = HOLD;
        load     = 1'b1;
        load_val = h_lp;
      end
      HOLD: if (expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobe is computed one cycle ahead so it can come straight off a flop.
    strobe_d = (state_d == PULSE) ? mask_q : '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      data_q   <= '0;
      mask_q   <= '0;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      strobe_q <= strobe_d;
    end
  end

  assign ready_o  = (state_q == IDLE) & ~reset_i;
  assign data_o   = data_q;
  assign strobe_o = strobe_q;

`ifdef BSG_GATESTACK_STROBE_GEN_DONE_EN
  logic done_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) done_q <= 1'b0;
    else         done_q <= (state_q == HOLD) & expire;
  end

  assign done_o = done_q;
`else
  assign done_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_gatestack_strobe_gen.sv
// Directed bench for bsg_gatestack_strobe_gen (default and S3/P2/H4).
// done_o expectations follow BSG_GATESTACK_STROBE_GEN_DONE_EN.
module tb_bsg_gatestack_strobe_gen;

`ifdef BSG_GATESTACK_STROBE_GEN_DONE_EN
  localparam logic DE = 1'b1;
`else
  localparam logic DE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v_a = 1'b0;
  logic        v_b = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] msk = '0;

  logic        rdy_a, rdy_b, done_a, done_b;
  logic [15:0] dat_a, dat_b, stb_a, stb_b;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  bsg_gatestack_strobe_gen dut_a (
    .clk_i   (clk),
    .reset_i (rst),
    .v_i     (v_a),
    .data_i  (din),
    .mask_i  (msk),
    .ready_o (rdy_a),
    .data_o  (dat_a),
    .strobe_o(stb_a),
    .done_o  (done_a)
  );

  bsg_gatestack_strobe_gen #(
    .setup_cycles_p(3),
    .pulse_cycles_p(2),
    .hold_cycles_p (4)
  ) dut_b (
    .clk_i   (clk),
    .reset_i (rst),
    .v_i     (v_b),
    .data_i  (din),
    .mask_i  (msk),
    .ready_o (rdy_b),
    .data_o  (dat_b),
    .strobe_o(stb_b),
    .done_o  (done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_ready", 32'(rdy_a), 32'd0);
    chk("rst_data", 32'(dat_a), 32'h0);
    chk("rst_strobe", 32'(stb_a), 32'h0);
    chk("rst_done", 32'(done_a), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("idle_ready", 32'(rdy_a), 32'd1);

    // T1: default params, full mask
    din = 16'hA5C3; msk = 16'hFFFF; v_a = 1'b1;
    step();
    v_a = 1'b0;
    chk("t1_data", 32'(dat_a), 32'hA5C3);
    chk("t1_stb0", 32'(stb_a), 32'h0);
    chk("t1_rdy0", 32'(rdy_a), 32'd0);
    step();
    chk("t1_stb1", 32'(stb_a), 32'hFFFF);
    chk("t1_rdy1", 32'(rdy_a), 32'd0);
    step();
    chk("t1_stb2", 32'(stb_a), 32'h0);
    chk("t1_rdy2", 32'(rdy_a), 32'd0);
    chk("t1_done2", 32'(done_a), 32'd0);
    step();
    chk("t1_rdy3", 32'(rdy_a), 32'd1);
    chk("t1_done3", 32'(done_a), 32'(DE));
    chk("t1_data3", 32'(dat_a), 32'hA5C3);
    step();
    chk("t1_done4", 32'(done_a), 32'd0);

    // T2: S3/P2/H4, sparse mask
    din = 16'hBEEF; msk = 16'h0101; v_b = 1'b1;
    step();
    v_b = 1'b0;
    for (int k = 0; k < 9; k++) begin
      chk("t2_data", 32'(dat_b), 32'hBEEF);
      chk("t2_stb", 32'(stb_b), (k == 3 || k == 4) ? 32'h0101 : 32'h0);
      chk("t2_rdy", 32'(rdy_b), 32'd0);
      chk("t2_done", 32'(done_b), 32'd0);
      step();
    end
    chk("t2_rdy_end", 32'(rdy_b), 32'd1);
    chk("t2_done_end", 32'(done_b), 32'(DE));
    step();
    chk("t2_done_after", 32'(done_b), 32'd0);

    // T3: zero mask
    din = 16'h0F0F; msk = 16'h0000; v_a = 1'b1;
    step();
    v_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_data", 32'(dat_a), 32'h0F0F);
      chk("t3_stb", 32'(stb_a), 32'h0);
      chk("t3_rdy", 32'(rdy_a), 32'd0);
      step();
    end
    chk("t3_rdy_end", 32'(rdy_a), 32'd1);
    chk("t3_done", 32'(done_a), 32'(DE));
    step();

    // T4: back-to-back with v held high
    din = 16'h1234; msk = 16'h00F0; v_a = 1'b1;
    step();
    din = 16'h5678;
    chk("t4_data0", 32'(dat_a), 32'h1234);
    chk("t4_rdy0", 32'(rdy_a), 32'd0);
    step();
    chk("t4_data1", 32'(dat_a), 32'h1234);
    chk("t4_stb1", 32'(stb_a), 32'h00F0);
    step();
    chk("t4_data2", 32'(dat_a), 32'h1234);
    chk("t4_rdy2", 32'(rdy_a), 32'd0);
    step();
    chk("t4_data3", 32'(dat_a), 32'h1234);
    chk("t4_rdy3", 32'(rdy_a), 32'd1);
    step();
    v_a = 1'b0;
    chk("t4_data4", 32'(dat_a), 32'h5678);
    chk("t4_rdy4", 32'(rdy_a), 32'd0);
    step();
    step();
    step();
    chk("t4_idle", 32'(rdy_a), 32'd1);

    // T5: async reset during PULSE
    din = 16'hC3C3; msk = 16'hFFFF; v_a = 1'b1;
    step();
    v_a = 1'b0;
    step();
    chk("t5_stb_pre", 32'(stb_a), 32'hFFFF);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_stb_rst", 32'(stb_a), 32'h0);
    chk("t5_data_rst", 32'(dat_a), 32'h0);
    chk("t5_rdy_rst", 32'(rdy_a), 32'd0);
    chk("t5_done_rst", 32'(done_a), 32'd0);
    step();
    chk("t5_rdy_hold", 32'(rdy_a), 32'd0);
    rst = 1'b0;
    step();
    chk("t5_rdy_rel", 32'(rdy_a), 32'd1);
    chk("t5_stb_rel", 32'(stb_a), 32'h0);
    chk("t5_done_rel", 32'(done_a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
